// File: rtl/wb_master_bridge_if.sv
// Bundles the command, response and Wishbone B4 master signals of wb_master_bridge.
// master is the bridge's view; slave is the view of whatever drives it.
interface wb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GRANULE    = 8
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

    // Command channel
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;
    logic [SEL_WIDTH-1:0]  cmd_sel_i;

    // Response channel
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    // Wishbone master side
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic                  we_o;
    logic                  cyc_o;
    logic                  stb_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;
    logic                  err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Converts a valid/ready command stream into classic single Wishbone B4 cycles,
// one transaction in flight, with ERR and timeout reporting on the response channel.
module wb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned GRANULE        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wb_master_bridge_if.master  bus
);
    localparam int unsigned SEL_WIDTH   = DATA_WIDTH / GRANULE;
    // Timeout fires on the cycle whose count would reach TIMEOUT_CYCLES.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        we_d          = we_q;
        cyc_d         = cyc_q;
        cnt_d         = cnt_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid_i) begin
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    we_d    = bus.cmd_we_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                // ERR outranks ACK, and any termination outranks the timeout.
                if (bus.err_i) begin
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    cyc_d         = 1'b0;
                    state_d       = StResp;
                end else if (bus.ack_i) begin
                    rsp_dat_d     = we_q ? '0 : bus.dat_i;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cyc_d         = 1'b0;
                    state_d       = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cyc_d         = 1'b0;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            cyc_q         <= 1'b0;
            cnt_q         <= '0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            cyc_q         <= cyc_d;
            cnt_q         <= cnt_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready_o   = (state_q == StIdle);
    assign bus.rsp_valid_o   = (state_q == StResp);
    assign bus.rsp_dat_o     = rsp_dat_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_timeout_q;

    // Classic single cycles: strobe and cycle always move together.
    assign bus.adr_o = adr_q;
    assign bus.dat_o = dat_q;
    assign bus.sel_o = sel_q;
    assign bus.we_o  = we_q;
    assign bus.cyc_o = cyc_q;
    assign bus.stb_o = cyc_q;

    a_cyc_tracks_state: assert property (
        @(posedge clk_i) disable iff (!rst_ni) cyc_q == (state_q == StBus)
    );

    a_bus_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == StBus && state_d == StBus) |=> $stable({adr_q, dat_q, sel_q, we_q, cyc_q})
    );

    a_rsp_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == StResp && !bus.rsp_ready_i)
            |=> (state_q == StResp) && $stable({rsp_dat_q, rsp_err_q, rsp_timeout_q})
    );
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: write, read, ERR, timeout, back-pressure, reset abort.
module tb_wb_master_bridge;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    wb_master_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8)) bus ();

    wb_master_bridge #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .GRANULE       (8),
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rdata);
        bus.dat_i = rdata;
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        bus.dat_i = '0;
    endtask

    task automatic take_rsp(input string tag);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check({tag, "_rsp_drop"}, bus.rsp_valid_o, 0);
        check({tag, "_ready_back"}, bus.cmd_ready_o, 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n           = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.dat_i       = '0;
        bus.ack_i       = 1'b0;
        bus.err_i       = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cyc", bus.cyc_o, 0);
        check("rst_stb", bus.stb_o, 0);
        check("rst_we", bus.we_o, 0);
        check("rst_adr", bus.adr_o, 0);
        check("rst_dat", bus.dat_o, 0);
        check("rst_sel", bus.sel_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_rsp_err", bus.rsp_err_o, 0);
        check("rst_rsp_to", bus.rsp_timeout_o, 0);
        check("rst_rsp_dat", bus.rsp_dat_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.cmd_ready_o, 1);

        // Terminations outside BUS are ignored
        bus.ack_i = 1'b1;
        bus.err_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        check("idle_ack_rsp", bus.rsp_valid_o, 0);
        check("idle_ack_cyc", bus.cyc_o, 0);

        // Write, ack two cycles after acceptance
        issue(1'b1, 16'h0003, 32'hDEAD_BEEF, 4'hF);
        check("wr_stb", bus.stb_o, 1);
        check("wr_cyc", bus.cyc_o, 1);
        check("wr_we", bus.we_o, 1);
        check("wr_adr", bus.adr_o, 16'h0003);
        check("wr_dat", bus.dat_o, 32'hDEAD_BEEF);
        check("wr_sel", bus.sel_o, 4'hF);
        check("wr_busy", bus.cmd_ready_o, 0);
        @(negedge clk);
        check("wr_stb_held", bus.stb_o, 1);
        check("wr_adr_held", bus.adr_o, 16'h0003);
        ack_now(32'hFFFF_FFFF);
        check("wr_stb_low", bus.stb_o, 0);
        check("wr_rsp_valid", bus.rsp_valid_o, 1);
        check("wr_rsp_err", bus.rsp_err_o, 0);
        check("wr_rsp_dat", bus.rsp_dat_o, 0);
        take_rsp("wr");

        // Read, immediate ack
        issue(1'b0, 16'h0003, 32'h0, 4'hF);
        check("rd_we", bus.we_o, 0);
        ack_now(32'hDEAD_BEEF);
        check("rd_stb_low", bus.stb_o, 0);
        check("rd_rsp_valid", bus.rsp_valid_o, 1);
        check("rd_rsp_dat", bus.rsp_dat_o, 32'hDEAD_BEEF);
        check("rd_rsp_err", bus.rsp_err_o, 0);
        check("rd_rsp_to", bus.rsp_timeout_o, 0);
        take_rsp("rd");

        // ERR together with ACK counts as error
        issue(1'b0, 16'h0010, 32'h0, 4'h3);
        bus.err_i = 1'b1;
        ack_now(32'h1234_5678);
        bus.err_i = 1'b0;
        check("err_rsp_valid", bus.rsp_valid_o, 1);
        check("err_rsp_err", bus.rsp_err_o, 1);
        check("err_rsp_to", bus.rsp_timeout_o, 0);
        check("err_rsp_dat", bus.rsp_dat_o, 0);
        check("err_stb_low", bus.stb_o, 0);
        take_rsp("err");

        // Timeout: strobe high exactly 4 cycles
        issue(1'b0, 16'h0020, 32'h0, 4'hF);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.stb_o) break;
            hi++;
            @(negedge clk);
        end
        check("to_stb_cycles", hi, 4);
        check("to_rsp_valid", bus.rsp_valid_o, 1);
        check("to_rsp_err", bus.rsp_err_o, 1);
        check("to_rsp_to", bus.rsp_timeout_o, 1);
        check("to_rsp_dat", bus.rsp_dat_o, 0);
        take_rsp("to");

        // Ack on the timeout cycle wins over the timeout
        issue(1'b0, 16'h0021, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        check("race_stb", bus.stb_o, 1);
        ack_now(32'hA5A5_A5A5);
        check("race_rsp_err", bus.rsp_err_o, 0);
        check("race_rsp_to", bus.rsp_timeout_o, 0);
        check("race_rsp_dat", bus.rsp_dat_o, 32'hA5A5_A5A5);
        take_rsp("race");

        // Response back-pressure with a second command waiting
        issue(1'b0, 16'h0040, 32'h0, 4'hF);
        ack_now(32'h0BAD_F00D);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 16'h0055;
        bus.cmd_dat_i   = 32'h5555_AAAA;
        bus.cmd_sel_i   = 4'h1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus.rsp_valid_o, 1);
            check("bp_rsp_dat", bus.rsp_dat_o, 32'h0BAD_F00D);
            check("bp_cmd_ready", bus.cmd_ready_o, 0);
            check("bp_stb", bus.stb_o, 0);
            check("bp_adr", bus.adr_o, 16'h0040);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("bp_gap_stb", bus.stb_o, 0);
        check("bp_gap_rsp", bus.rsp_valid_o, 0);
        check("bp_gap_ready", bus.cmd_ready_o, 1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check("bp_second_stb", bus.stb_o, 1);
        check("bp_second_adr", bus.adr_o, 16'h0055);
        check("bp_second_we", bus.we_o, 1);
        ack_now(32'h0);
        take_rsp("bp");

        // Reset in the middle of a bus cycle
        issue(1'b0, 16'h0077, 32'h0, 4'hF);
        check("mrst_stb_pre", bus.stb_o, 1);
        #2;
        rst_n     = 1'b0;
        bus.ack_i = 1'b1;
        #1;
        check("mrst_stb", bus.stb_o, 0);
        check("mrst_cyc", bus.cyc_o, 0);
        check("mrst_rsp", bus.rsp_valid_o, 0);
        @(negedge clk);
        bus.ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_ready", bus.cmd_ready_o, 1);
        check("mrst_no_rsp", bus.rsp_valid_o, 0);
        issue(1'b1, 16'h0099, 32'hCAFE_0001, 4'hC);
        check("mrst_first_stb", bus.stb_o, 1);
        check("mrst_first_adr", bus.adr_o, 16'h0099);
        ack_now(32'h0);
        check("mrst_first_rsp", bus.rsp_valid_o, 1);
        take_rsp("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (8/16/32/64).
REQ-003 SHALL have parameter GRANULE, default 8, select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum bus-phase cycles before abort (legal range 1..65535).
REQ-005 SHALL have ports as follows, each one line: name, direction, width, meaning.
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  target address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  SEL_WIDTH  byte-lane select.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_dat_o  out  DATA_WIDTH  read data; zero for writes and errors.
- rsp_err_o  out  1  slave signalled ERR or timeout.
- rsp_timeout_o  out  1  abort caused by timeout.
- adr_o, dat_o, sel_o, we_o  out  ADDR_WIDTH/DATA_WIDTH/SEL_WIDTH/1  Wishbone B4 master outputs.
- cyc_o, stb_o  out  1  Wishbone cycle/strobe, registered.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- ack_i, err_i  in  1  Wishbone termination from slave.

Function
REQ-006 SHALL implement a 3-state FSM: IDLE, BUS, RESP; one outstanding transaction, classic single read/write cycles only.
REQ-007 SHALL drive cmd_ready_o = 1 only in IDLE (combinational from state).
REQ-008 SHALL, in IDLE on cmd_valid_i, register we/adr/dat/sel onto we_o/adr_o/dat_o/sel_o, set cyc_o = stb_o = 1 on the next edge, clear the timeout counter, enter BUS.
REQ-009 SHALL hold adr_o, dat_o, sel_o, we_o, cyc_o, stb_o stable throughout BUS.
REQ-010 SHALL increment a timeout counter each BUS cycle without ack_i/err_i.
REQ-011 SHALL, in BUS on ack_i without err_i, capture dat_i into rsp_dat_o (reads only; writes load 0), clear rsp_err_o/rsp_timeout_o, deassert cyc_o/stb_o on the next edge, enter RESP.
REQ-012 SHALL, in BUS on err_i (regardless of ack_i), set rsp_err_o = 1, rsp_timeout_o = 0, rsp_dat_o = 0, deassert cyc_o/stb_o, enter RESP; simultaneous ack_i and err_i count as error.
REQ-013 SHALL, when the counter reaches TIMEOUT_CYCLES with no termination, set rsp_err_o = rsp_timeout_o = 1, rsp_dat_o = 0, deassert cyc_o/stb_o, enter RESP; termination on the same cycle as the timeout takes priority over the timeout.
REQ-014 SHALL ignore ack_i/err_i outside BUS.
REQ-015 SHALL assert rsp_valid_o only in RESP and hold all rsp_* stable until rsp_ready_i; on rsp_ready_i return to IDLE.
REQ-016 SHALL guarantee stb_o low for at least one full cycle between consecutive transactions, so a slave waiting for strobe end can release.
REQ-017 SHALL give latency: cmd accepted at edge N -> stb_o high after N; termination sampled at edge M -> stb_o low and rsp_valid_o high after M.
REQ-018 SHALL keep cmd_ready_o low during BUS and RESP, so back-to-back commands are throttled without loss.

Reset
REQ-019 SHALL, on rst_ni low, immediately (asynchronously) force state IDLE, cyc_o = stb_o = we_o = 0, adr_o/dat_o/sel_o/rsp_dat_o = 0, rsp_valid_o = rsp_err_o = rsp_timeout_o = 0, counter = 0.
REQ-020 SHALL, on reset mid-BUS, drop cyc_o/stb_o within the same cycle and produce no response for the aborted command.
REQ-021 SHALL leave cmd_ready_o = 1 after reset release, with the first command accepted on the first edge with rst_ni high.

Verification
REQ-022 Write adr 0x0003, dat 0xDEADBEEF, sel 0xF, ack after 2 cycles -> we_o=1, stb_o held, rsp_valid_o with rsp_err_o=0, rsp_dat_o=0.
REQ-023 Read adr 0x0003, slave returns 0xDEADBEEF with ack -> rsp_dat_o=0xDEADBEEF, rsp_err_o=0, stb_o low one cycle after ack.
REQ-024 Read with err_i=1 and ack_i=1 on the same cycle -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
REQ-025 TIMEOUT_CYCLES=4, slave never responds -> stb_o high exactly 4 cycles, then rsp_err_o=1, rsp_timeout_o=1.
REQ-026 rsp_ready_i held low 5 cycles, cmd_valid_i held high -> rsp_* stable, cmd_ready_o=0, second command starts only after handshake plus one stb_o-low cycle.
REQ-027 rst_ni pulsed low mid-BUS -> cyc_o/stb_o low same cycle, no rsp_valid_o, cmd_ready_o=1 after release.
